// File: rtl/align_pp_lanes.sv
// Two-stage pipeline that aligns signed partial-product lanes to the beat's maximum exponent.
// Optional per-lane sticky output is built when ALIGN_STICKY_EN is defined.
module align_pp_lanes #(
  parameter int LANES  = 4,
  parameter int MANT_W = 3,
  parameter int EXP_W  = 6,
  parameter int OUT_W  = 15,
  parameter int QF_W   = 5
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [LANES*(MANT_W+1)-1:0]  i_denorm_pp,
  input  logic [LANES*EXP_W-1:0]       i_exp,
  input  logic [LANES-1:0]             i_lane_en,
  input  logic [QF_W-1:0]              i_Q_frac,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [LANES*OUT_W-1:0]       o_align_pp,
  output logic [EXP_W-1:0]             o_max_exp,
`ifdef ALIGN_STICKY_EN
  output logic [LANES-1:0]             o_sticky,
`endif
  output logic [QF_W-1:0]              o_Q_frac
);

  localparam int FW = OUT_W - 1;
  localparam logic [EXP_W:0] FW_LIM = (EXP_W+1)'(FW);

  function automatic logic [FW-1:0] align_field(input logic [MANT_W-1:0] mag,
                                                input logic [EXP_W-1:0]  diff);
    logic [FW-1:0] placed;
    placed = '0;
    placed[FW-1 -: MANT_W] = mag;
    if ({1'b0, diff} >= FW_LIM) return '0;
    return placed >> diff;
  endfunction

`ifdef ALIGN_STICKY_EN
  function automatic logic align_sticky(input logic [MANT_W-1:0] mag,
                                        input logic [EXP_W-1:0]  diff);
    logic [2*FW-1:0] wide;
    if ({1'b0, diff} >= FW_LIM) return |mag;
    wide = '0;
    wide[2*FW-1 -: MANT_W] = mag;
    wide = wide >> diff;
    return |wide[FW-1:0];
  endfunction
`endif

  function automatic logic signed [OUT_W-1:0] to_lane(input logic sign,
                                                      input logic [FW-1:0] field);
    logic signed [OUT_W-1:0] v;
    v = $signed({1'b0, field});
    return sign ? -v : v;
  endfunction

  logic                     vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [LANES-1:0]         sign_p1_q, sign_p1_d, en_p1_q, en_p1_d;
  logic [LANES*MANT_W-1:0]  mag_p1_q, mag_p1_d;
  logic [LANES*EXP_W-1:0]   diff_p1_q, diff_p1_d;
  logic [EXP_W-1:0]         maxe_p1_q, maxe_p1_d, maxe_p2_q, maxe_p2_d;
  logic [QF_W-1:0]          qf_p1_q, qf_p1_d, qf_p2_q, qf_p2_d;
  logic [LANES*OUT_W-1:0]   lanes_p2_q, lanes_p2_d;
`ifdef ALIGN_STICKY_EN
  logic [LANES-1:0]         sticky_p2_q, sticky_p2_d;
`endif
  logic [EXP_W-1:0]         max_exp_c;
  logic                     ld2, adv1, acc_in;

  assign ld2     = !vld_p2_q || i_ready;
  assign adv1    = vld_p1_q && ld2;
  assign o_ready = !i_rst && (!vld_p1_q || ld2);
  assign acc_in  = i_valid && o_ready;

  always_comb begin
    max_exp_c = '0;
    for (int k = 0; k < LANES; k++)
      if (i_lane_en[k] && (i_exp[k*EXP_W +: EXP_W] > max_exp_c))
        max_exp_c = i_exp[k*EXP_W +: EXP_W];
  end

  // Stage 1: capture lanes, exponent differences and beat maximum
  always_comb begin
    vld_p1_d  = acc_in ? 1'b1 : (adv1 ? 1'b0 : vld_p1_q);
    sign_p1_d = sign_p1_q;
    en_p1_d   = en_p1_q;
    mag_p1_d  = mag_p1_q;
    diff_p1_d = diff_p1_q;
    maxe_p1_d = maxe_p1_q;
    qf_p1_d   = qf_p1_q;
    if (acc_in) begin
      en_p1_d   = i_lane_en;
      maxe_p1_d = max_exp_c;
      qf_p1_d   = i_Q_frac;
      for (int k = 0; k < LANES; k++) begin
        sign_p1_d[k] = i_denorm_pp[k*(MANT_W+1) + MANT_W];
        mag_p1_d[k*MANT_W +: MANT_W] = i_denorm_pp[k*(MANT_W+1) +: MANT_W];
        diff_p1_d[k*EXP_W +: EXP_W]  = max_exp_c - i_exp[k*EXP_W +: EXP_W];
      end
    end
  end

  // Stage 2: shift, negate and mask disabled lanes
  always_comb begin
    vld_p2_d   = ld2 ? vld_p1_q : vld_p2_q;
    lanes_p2_d = lanes_p2_q;
    maxe_p2_d  = maxe_p2_q;
    qf_p2_d    = qf_p2_q;
`ifdef ALIGN_STICKY_EN
    sticky_p2_d = sticky_p2_q;
`endif
    if (adv1) begin
      maxe_p2_d = maxe_p1_q;
      qf_p2_d   = qf_p1_q;
      for (int k = 0; k < LANES; k++) begin
        lanes_p2_d[k*OUT_W +: OUT_W] = en_p1_q[k]
          ? to_lane(sign_p1_q[k], align_field(mag_p1_q[k*MANT_W +: MANT_W],
                                              diff_p1_q[k*EXP_W +: EXP_W]))
          : '0;
`ifdef ALIGN_STICKY_EN
        sticky_p2_d[k] = en_p1_q[k] &&
          align_sticky(mag_p1_q[k*MANT_W +: MANT_W], diff_p1_q[k*EXP_W +: EXP_W]);
`endif
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      sign_p1_q  <= '0;
      en_p1_q    <= '0;
      mag_p1_q   <= '0;
      diff_p1_q  <= '0;
      maxe_p1_q  <= '0;
      qf_p1_q    <= '0;
      lanes_p2_q <= '0;
      maxe_p2_q  <= '0;
      qf_p2_q    <= '0;
`ifdef ALIGN_STICKY_EN
      sticky_p2_q <= '0;
`endif
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      sign_p1_q  <= sign_p1_d;
      en_p1_q    <= en_p1_d;
      mag_p1_q   <= mag_p1_d;
      diff_p1_q  <= diff_p1_d;
      maxe_p1_q  <= maxe_p1_d;
      qf_p1_q    <= qf_p1_d;
      lanes_p2_q <= lanes_p2_d;
      maxe_p2_q  <= maxe_p2_d;
      qf_p2_q    <= qf_p2_d;
`ifdef ALIGN_STICKY_EN
      sticky_p2_q <= sticky_p2_d;
`endif
    end
  end

  assign o_valid    = vld_p2_q;
  assign o_align_pp = lanes_p2_q;
  assign o_max_exp  = maxe_p2_q;
  assign o_Q_frac   = qf_p2_q;
`ifdef ALIGN_STICKY_EN
  assign o_sticky   = sticky_p2_q;
`endif

endmodule

// File: tb/tb_align_pp_lanes.sv
// Randomized and directed bench for align_pp_lanes with an in-bench behavioural reference.
module tb_align_pp_lanes;
  localparam int L = 4, MW = 3, EW = 6, OW = 15, QW = 5;
  localparam int FW = OW - 1;

  logic              clk = 0, rst = 1;
  logic              i_valid = 0, i_ready = 1, o_ready, o_valid;
  logic [L*(MW+1)-1:0] pp_in = '0;
  logic [L*EW-1:0]   ex_in = '0;
  logic [L-1:0]      en_in = '0;
  logic [QW-1:0]     qf_in = '0;
  logic [L*OW-1:0]   o_pp;
  logic [EW-1:0]     o_me;
  logic [QW-1:0]     o_qf;
`ifdef ALIGN_STICKY_EN
  logic [L-1:0]      o_st;
`endif

  align_pp_lanes #(.LANES(L), .MANT_W(MW), .EXP_W(EW), .OUT_W(OW), .QF_W(QW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_denorm_pp(pp_in), .i_exp(ex_in), .i_lane_en(en_in), .i_Q_frac(qf_in),
    .o_valid(o_valid), .i_ready(i_ready), .o_align_pp(o_pp), .o_max_exp(o_me),
`ifdef ALIGN_STICKY_EN
    .o_sticky(o_st),
`endif
    .o_Q_frac(o_qf));

  always #5 clk = ~clk;

  typedef struct {
    logic [L*OW-1:0] pp;
    logic [EW-1:0]   me;
    logic [QW-1:0]   qf;
    logic [L-1:0]    st;
  } beat_t;

  beat_t q[$];
  int n_tests = 0, n_fail = 0;

  function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
    end
  endfunction

  function automatic beat_t model(input logic [L*(MW+1)-1:0] pp, input logic [L*EW-1:0] ex,
                                  input logic [L-1:0] en, input logic [QW-1:0] qf);
    beat_t b;
    int me, mag, d, val, field, lane;
    logic [OW-1:0] lane_v;
    me = 0;
    for (int k = 0; k < L; k++)
      if (en[k] && int'(ex[k*EW +: EW]) > me) me = int'(ex[k*EW +: EW]);
    b.me = EW'(me);
    b.qf = qf;
    b.pp = '0;
    b.st = '0;
    for (int k = 0; k < L; k++) begin
      if (en[k]) begin
        mag = int'(pp[k*(MW+1) +: MW]);
        d   = me - int'(ex[k*EW +: EW]);
        val = mag * (1 << (FW - MW));
        if (d >= FW) begin
          field = 0;
          b.st[k] = (mag != 0);
        end else begin
          field = val >> d;
          b.st[k] = (val % (1 << d)) != 0;
        end
        lane = pp[k*(MW+1) + MW] ? ((1 << OW) - field) % (1 << OW) : field;
        lane_v = lane[OW-1:0];
        b.pp[k*OW +: OW] = lane_v;
      end
    end
    return b;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (rst) q.delete();
    else begin
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_unexpected got beat pp=%h expected none t=%0t", o_pp, $time);
        end else begin
          e = q.pop_front();
          check("sb_pp", 64'(o_pp), 64'(e.pp));
          check("sb_max_exp", 64'(o_me), 64'(e.me));
          check("sb_qfrac", 64'(o_qf), 64'(e.qf));
`ifdef ALIGN_STICKY_EN
          check("sb_sticky", 64'(o_st), 64'(e.st));
`endif
        end
      end
      if (i_valid && o_ready) q.push_back(model(pp_in, ex_in, en_in, qf_in));
    end
  end

  task automatic drive(input logic [L*(MW+1)-1:0] pp, input logic [L*EW-1:0] ex,
                       input logic [L-1:0] en, input logic [QW-1:0] qf);
    i_valid = 1; pp_in = pp; ex_in = ex; en_in = en; qf_in = qf;
  endtask

  // Single beat into an idle pipe with literal expected outputs two cycles later.
  task automatic one_beat(input string nm, input logic [L*(MW+1)-1:0] pp, input logic [L*EW-1:0] ex,
                          input logic [L-1:0] en, input logic [QW-1:0] qf,
                          input logic [L*OW-1:0] exp_pp, input logic [EW-1:0] exp_me,
                          input logic [L-1:0] exp_st);
    drive(pp, ex, en, qf);
    #1 check({nm, "_ready"}, 64'(o_ready), 64'd1);
    @(posedge clk); #1 i_valid = 0;
    @(posedge clk); #1;
    check({nm, "_valid"}, 64'(o_valid), 64'd1);
    check({nm, "_pp"}, 64'(o_pp), 64'(exp_pp));
    check({nm, "_max_exp"}, 64'(o_me), 64'(exp_me));
    check({nm, "_qfrac"}, 64'(o_qf), 64'(qf));
`ifdef ALIGN_STICKY_EN
    check({nm, "_sticky"}, 64'(o_st), 64'(exp_st));
`else
    if (exp_st != exp_st) $display("unused");
`endif
  endtask

  task automatic send_wait(input string nm, input logic [L*(MW+1)-1:0] pp, input logic [L*EW-1:0] ex,
                           input logic [L-1:0] en, input logic [QW-1:0] qf);
    bit got = 0;
    drive(pp, ex, en, qf);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (o_ready) begin got = 1; break; end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s_accept got no acceptance expected accept within 20 cycles", nm);
    end
    @(posedge clk); #1 i_valid = 0;
  endtask

  initial begin
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_pp", 64'(o_pp), 64'd0);
    check("rst_max_exp", 64'(o_me), 64'd0);
    check("rst_qfrac", 64'(o_qf), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    @(posedge clk); #1;

    one_beat("basic", 16'h6666, {6'd2, 6'd10, 6'd8, 6'd10}, 4'hF, 5'd7,
             {15'h0030, 15'h3000, 15'h0C00, 15'h3000}, 6'd10, 4'b0000);
    one_beat("neg", 16'h666F, {6'd5, 6'd5, 6'd5, 6'd5}, 4'hF, 5'd19,
             {15'h3000, 15'h3000, 15'h3000, 15'h4800}, 6'd5, 4'b0000);
    one_beat("far", 16'h0565, {6'd20, 6'd6, 6'd20, 6'd7}, 4'hF, 5'd3,
             {15'h0000, 15'h0000, 15'h3000, 15'h0001}, 6'd20, 4'b0101);
    one_beat("en_none", 16'hFFFF, {6'd63, 6'd40, 6'd12, 6'd1}, 4'h0, 5'd31,
             '0, 6'd0, 4'b0000);
    one_beat("en_one", 16'h9999, {6'd50, 6'd50, 6'd33, 6'd50}, 4'b0010, 5'd9,
             {15'h0000, 15'h0000, 15'h7800, 15'h0000}, 6'd33, 4'b0000);
    repeat (3) @(posedge clk); #1;

    // Backpressure: A and B fill both stages, C waits
    i_ready = 0;
    drive(16'h1234, {6'd1, 6'd2, 6'd3, 6'd4}, 4'hF, 5'd1);
    @(posedge clk); #1;
    drive(16'h5678, {6'd9, 6'd9, 6'd8, 6'd7}, 4'hF, 5'd2);
    @(posedge clk); #1;
    drive(16'h9ABC, {6'd0, 6'd30, 6'd31, 6'd29}, 4'hF, 5'd3);
    #1 check("stall_ready", 64'(o_ready), 64'd0);
    check("stall_valid", 64'(o_valid), 64'd1);
    repeat (2) @(posedge clk);
    #1 check("stall_ready_hold", 64'(o_ready), 64'd0);
    i_ready = 1;
    send_wait("beatC", 16'h9ABC, {6'd0, 6'd30, 6'd31, 6'd29}, 4'hF, 5'd3);
    repeat (5) @(posedge clk); #1;
    check("stall_drained", 64'(q.size()), 64'd0);

    // Reset with both stages full
    i_ready = 0;
    send_wait("rA", 16'h6666, {6'd4, 6'd4, 6'd4, 6'd4}, 4'hF, 5'd5);
    send_wait("rB", 16'h7777, {6'd3, 6'd3, 6'd3, 6'd3}, 4'hF, 5'd6);
    @(posedge clk); #2 rst = 1;
    #1;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_ready", 64'(o_ready), 64'd0);
    check("midrst_pp", 64'(o_pp), 64'd0);
    check("midrst_max_exp", 64'(o_me), 64'd0);
    check("midrst_qfrac", 64'(o_qf), 64'd0);
    i_valid = 0; i_ready = 1;
    @(posedge clk); #2 rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1 check("no_stale", 64'(o_valid), 64'd0);
    end
    one_beat("post_rst", 16'h6666, {6'd2, 6'd10, 6'd8, 6'd10}, 4'hF, 5'd11,
             {15'h0030, 15'h3000, 15'h0C00, 15'h3000}, 6'd10, 4'b0000);
    repeat (2) @(posedge clk); #1;

    // Randomized traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      logic [L*EW-1:0] ex;
      logic [5:0] base;
      base = 6'($urandom_range(0, 63));
      for (int k = 0; k < L; k++)
        ex[k*EW +: EW] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63))
                                                      : base - 6'($urandom_range(0, 16));
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      pp_in   = 16'($urandom);
      ex_in   = ex;
      en_in   = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      qf_in   = 5'($urandom);
      @(posedge clk); #1;
    end
    i_valid = 0; i_ready = 1;
    for (int c = 0; c < 50 && q.size() != 0; c++) @(posedge clk);
    #1 check("final_drain", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish expected finish before 2000000");
    $fatal(1, "timeout");
  end
endmodule
